// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: machine word, fetch-stage states and the
// canonical no-op encoding used to fill empty pipeline slots.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH,
    SKID,
    DRAIN
  } lc3b_fetch_state;

  // BR with nzp=000 never branches, so an all-zero word is a no-op.
  localparam lc3b_word LC3B_NOP = 16'h0000;

  // Instruction addresses are word aligned; bit 0 is always cleared.
  function automatic lc3b_word lc3b_align(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// Loadable/flushable pipeline register holding {IR, PC, valid}.
// Flush wins over load; flush empties the slot but leaves the PC field alone.
import lc3b_types::*;

module ifid_reg #(
  parameter lc3b_word NOP_WORD = LC3B_NOP
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     flush,
  input  lc3b_word ir_in,
  input  lc3b_word pc_in,
  output lc3b_word ir,
  output lc3b_word pc,
  output logic     valid
);

  // Register update: reset empties the slot, flush inserts a bubble, load captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir    <= NOP_WORD;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      ir    <= NOP_WORD;
      valid <= 1'b0;
    end else if (load) begin
      ir    <= ir_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// LC-3b fetch stage: owns the PC, drives the instruction-memory handshake
// and feeds decode through the IF/ID register. A one-entry skid buffer
// absorbs a response that arrives while decode is stalled, and the DRAIN
// state waits out a request that was in flight when a redirect arrived.
import lc3b_types::*;

module instruction_fetch #(
  parameter lc3b_word RESET_PC = 16'h0000,
  parameter lc3b_word NOP_WORD = LC3B_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        imem_read,
  output logic [15:0] imem_address,
  output logic [15:0] IR,
  output logic [15:0] pc_out,
  output logic        valid_out
);

  lc3b_fetch_state state;
  lc3b_word        pc;
  lc3b_word        pc_plus2;
  lc3b_word        skid_ir;
  lc3b_word        skid_pc;
  lc3b_word        target;
  logic            issue;
  logic            accept;
  logic            resp_ok;

  logic            ifid_load;
  logic            ifid_flush;
  lc3b_word        ifid_ir_in;
  lc3b_word        ifid_pc_in;

  // issue is low only in the bubble cycle after reset or after a redirect
  // that had nothing in flight; SKID never requests because the buffer is full.
  assign imem_read    = issue && (state != SKID);
  assign imem_address = pc;
  assign pc_plus2     = pc + 16'd2;
  assign accept       = !valid_out || !stall;
  // A response only counts when we actually asked for one.
  assign resp_ok      = imem_resp && imem_read;

  // IF/ID control: redirect flushes first, then fresh data or the skid
  // buffer loads, and an unreplaced consumed slot turns into a bubble.
  always_comb begin
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_ir_in = imem_rdata;
    ifid_pc_in = pc_plus2;
    if (redirect) begin
      ifid_flush = 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (resp_ok) begin
            if (accept) ifid_load = 1'b1;
          end else if (!stall) begin
            ifid_flush = 1'b1;
          end
        end
        SKID: begin
          if (!stall) begin
            ifid_load  = 1'b1;
            ifid_ir_in = skid_ir;
            ifid_pc_in = skid_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Fetch FSM: PC, skid buffer, latched redirect target and request enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= lc3b_align(RESET_PC);
      skid_ir <= NOP_WORD;
      skid_pc <= '0;
      target  <= '0;
      issue   <= 1'b0;
    end else begin
      issue <= 1'b1;
      case (state)
        FETCH: begin
          if (redirect) begin
            if (imem_read && !imem_resp) begin
              target <= lc3b_align(redirect_pc);
              state  <= DRAIN;
            end else begin
              pc <= lc3b_align(redirect_pc);
              if (!imem_read) issue <= 1'b0;
            end
          end else if (resp_ok) begin
            pc <= pc_plus2;
            if (!accept) begin
              skid_ir <= imem_rdata;
              skid_pc <= pc_plus2;
              state   <= SKID;
            end
          end
        end
        SKID: begin
          if (redirect) begin
            skid_ir <= NOP_WORD;
            skid_pc <= '0;
            pc      <= lc3b_align(redirect_pc);
            issue   <= 1'b0;
            state   <= FETCH;
          end else if (!stall) begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (resp_ok) begin
            pc    <= redirect ? lc3b_align(redirect_pc) : target;
            state <= FETCH;
          end else if (redirect) begin
            target <= lc3b_align(redirect_pc);
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  ifid_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_ifid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ifid_load),
    .flush (ifid_flush),
    .ir_in (ifid_ir_in),
    .pc_in (ifid_pc_in),
    .ir    (IR),
    .pc    (pc_out),
    .valid (valid_out)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for the LC-3b fetch stage. Inputs change on the falling
// edge and outputs are sampled on the following falling edge.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] ir;
  logic [15:0] pc_out;
  logic        valid_out;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .IR           (ir),
    .pc_out       (pc_out),
    .valid_out    (valid_out)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it, sample at the next falling edge.
  task automatic step(input logic resp, input logic [15:0] rdata, input logic stl,
                      input logic redir, input logic [15:0] rpc);
    imem_resp   = resp;
    imem_rdata  = rdata;
    stall       = stl;
    redirect    = redir;
    redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_resp = 1'b0; imem_rdata = 16'h0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ir !== 16'h0000) begin errors++; $display("[TB] FAIL reset_ir: got %h expected %h", ir, 16'h0000); end
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc_out: got %h expected %h", pc_out, 16'h0000); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (imem_address !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected %h", imem_address, 16'h0000); end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checks++; if (imem_read !== 1'b1) begin errors++; $display("[TB] FAIL reset_read_after: got %b expected 1", imem_read); end
  endtask

  task automatic test_sequential_fetch();
    do_reset();
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checks++; if (imem_address !== 16'h0000) begin errors++; $display("[TB] FAIL seq_addr0: got %h expected %h", imem_address, 16'h0000); end
    step(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0);
    checks++; if (ir !== 16'h1234) begin errors++; $display("[TB] FAIL seq_ir0: got %h expected %h", ir, 16'h1234); end
    checks++; if (pc_out !== 16'h0002) begin errors++; $display("[TB] FAIL seq_pc0: got %h expected %h", pc_out, 16'h0002); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid0: got %b expected 1", valid_out); end
    checks++; if (imem_address !== 16'h0002) begin errors++; $display("[TB] FAIL seq_addr1: got %h expected %h", imem_address, 16'h0002); end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL seq_bubble_valid: got %b expected 0", valid_out); end
    checks++; if (imem_read !== 1'b1) begin errors++; $display("[TB] FAIL seq_bubble_read: got %b expected 1", imem_read); end
    step(1'b1, 16'h5678, 1'b0, 1'b0, 16'h0);
    checks++; if (ir !== 16'h5678) begin errors++; $display("[TB] FAIL seq_ir1: got %h expected %h", ir, 16'h5678); end
    checks++; if (pc_out !== 16'h0004) begin errors++; $display("[TB] FAIL seq_pc1: got %h expected %h", pc_out, 16'h0004); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid1: got %b expected 1", valid_out); end
  endtask

  task automatic test_stall_skid();
    do_reset();
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0);
    step(1'b1, 16'h5678, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (ir !== 16'h1234) begin errors++; $display("[TB] FAIL stall_ir_hold[%0d]: got %h expected %h", i, ir, 16'h1234); end
      checks++; if (imem_read !== 1'b0) begin errors++; $display("[TB] FAIL stall_skid_read[%0d]: got %b expected 0", i, imem_read); end
      if (i < 2) step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    end
    checks++; if (pc_out !== 16'h0002) begin errors++; $display("[TB] FAIL stall_pc_hold: got %h expected %h", pc_out, 16'h0002); end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checks++; if (ir !== 16'h5678) begin errors++; $display("[TB] FAIL stall_release_ir: got %h expected %h", ir, 16'h5678); end
    checks++; if (pc_out !== 16'h0004) begin errors++; $display("[TB] FAIL stall_release_pc: got %h expected %h", pc_out, 16'h0004); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_valid: got %b expected 1", valid_out); end
    checks++; if (imem_read !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_read: got %b expected 1", imem_read); end
    checks++; if (imem_address !== 16'h0004) begin errors++; $display("[TB] FAIL stall_release_addr: got %h expected %h", imem_address, 16'h0004); end
  endtask

  task automatic test_redirect_idle();
    // Continues from the stall test: IR=5678 valid, fetching 0x0004.
    step(1'b1, 16'h9999, 1'b1, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h3000);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid: got %b expected 0", valid_out); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("[TB] FAIL redir_ir: got %h expected %h", ir, 16'h0000); end
    checks++; if (imem_read !== 1'b0) begin errors++; $display("[TB] FAIL redir_bubble_read: got %b expected 0", imem_read); end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checks++; if (imem_read !== 1'b1) begin errors++; $display("[TB] FAIL redir_read: got %b expected 1", imem_read); end
    checks++; if (imem_address !== 16'h3000) begin errors++; $display("[TB] FAIL redir_addr: got %h expected %h", imem_address, 16'h3000); end
  endtask

  task automatic test_redirect_drain();
    // Redirect coinciding with a response: data discarded, no bubble.
    step(1'b1, 16'hAAAA, 1'b0, 1'b1, 16'h0010);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL drain_setup_valid: got %b expected 0", valid_out); end
    checks++; if (imem_address !== 16'h0010) begin errors++; $display("[TB] FAIL drain_setup_addr: got %h expected %h", imem_address, 16'h0010); end
    checks++; if (imem_read !== 1'b1) begin errors++; $display("[TB] FAIL drain_setup_read: got %b expected 1", imem_read); end
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h2222);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h4001);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checks++; if (imem_address !== 16'h0010) begin errors++; $display("[TB] FAIL drain_old_addr: got %h expected %h", imem_address, 16'h0010); end
    checks++; if (imem_read !== 1'b1) begin errors++; $display("[TB] FAIL drain_read: got %b expected 1", imem_read); end
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    checks++; if (ir !== 16'h0000) begin errors++; $display("[TB] FAIL drain_discard_ir: got %h expected %h", ir, 16'h0000); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL drain_discard_valid: got %b expected 0", valid_out); end
    checks++; if (imem_address !== 16'h4000) begin errors++; $display("[TB] FAIL drain_target_addr: got %h expected %h", imem_address, 16'h4000); end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checks++; if (ir === 16'hBEEF) begin errors++; $display("[TB] FAIL drain_never_beef: got %h expected not %h", ir, 16'hBEEF); end
  endtask

  task automatic test_wrap();
    step(1'b1, 16'h0, 1'b0, 1'b1, 16'hFFFE);
    checks++; if (imem_address !== 16'hFFFE) begin errors++; $display("[TB] FAIL wrap_addr_pre: got %h expected %h", imem_address, 16'hFFFE); end
    step(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0);
    checks++; if (ir !== 16'h1111) begin errors++; $display("[TB] FAIL wrap_ir: got %h expected %h", ir, 16'h1111); end
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_pc_out: got %h expected %h", pc_out, 16'h0000); end
    checks++; if (imem_address !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected %h", imem_address, 16'h0000); end
  endtask

  task automatic test_async_reset();
    step(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0);
    checks++; if (imem_address !== 16'h0002) begin errors++; $display("[TB] FAIL areset_pre_addr: got %h expected %h", imem_address, 16'h0002); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ir !== 16'h0000) begin errors++; $display("[TB] FAIL areset_ir: got %h expected %h", ir, 16'h0000); end
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("[TB] FAIL areset_pc_out: got %h expected %h", pc_out, 16'h0000); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %b expected 0", valid_out); end
    checks++; if (imem_read !== 1'b0) begin errors++; $display("[TB] FAIL areset_read: got %b expected 0", imem_read); end
    checks++; if (imem_address !== 16'h0000) begin errors++; $display("[TB] FAIL areset_addr: got %h expected %h", imem_address, 16'h0000); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL areset_late_resp: got %b expected 0", valid_out); end
    checks++; if (imem_address !== 16'h0000) begin errors++; $display("[TB] FAIL areset_first_addr: got %h expected %h", imem_address, 16'h0000); end
    checks++; if (imem_read !== 1'b1) begin errors++; $display("[TB] FAIL areset_first_read: got %b expected 1", imem_read); end
    step(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0);
    checks++; if (ir !== 16'h7777) begin errors++; $display("[TB] FAIL areset_fetch_ir: got %h expected %h", ir, 16'h7777); end
    checks++; if (pc_out !== 16'h0002) begin errors++; $display("[TB] FAIL areset_fetch_pc: got %h expected %h", pc_out, 16'h0002); end
  endtask

  // Scenario sequence; each task leaves the DUT where the next one expects it.
  initial begin
    rst_n = 1'b0;
    imem_resp = 1'b0; imem_rdata = 16'h0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    @(negedge clk);
    test_reset();
    test_sequential_fetch();
    test_stall_skid();
    test_redirect_idle();
    test_redirect_drain();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
